// File: rtl/karaoke_pkg.sv
// Shared types and constants for the karaoke vocal remover datapath.
package karaoke_pkg;

    localparam int DATA_W_DEF = 32;

    localparam logic [DATA_W_DEF-1:0] SAT_MAX = 32'h7FFF_FFFF;
    localparam logic [DATA_W_DEF-1:0] SAT_MIN = 32'h8000_0000;

    typedef enum logic [1:0] {
        CAPTURE = 2'd0,
        COMPUTE = 2'd1,
        EMIT    = 2'd2
    } state_t;

endpackage

// File: rtl/karaoke_diff_sat.sv
// Combinational L-R difference: saturated when KARAOKE_FULL_GAIN_EN is defined,
// otherwise halved (arithmetic shift), which can never overflow.
module karaoke_diff_sat #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic [DATA_W-1:0] o_result
`ifdef KARAOKE_FULL_GAIN_EN
    ,
    output logic              o_sat
`endif
);

    logic signed [DATA_W:0] w_diff;

    assign w_diff = {i_a[DATA_W-1], i_a} - {i_b[DATA_W-1], i_b};

`ifdef KARAOKE_FULL_GAIN_EN
    logic [DATA_W-1:0] w_max;
    logic [DATA_W-1:0] w_min;
    logic              w_ovf;

    assign w_max = {1'b0, {(DATA_W-1){1'b1}}};
    assign w_min = {1'b1, {(DATA_W-1){1'b0}}};
    // The extra sign bit disagreeing with the top result bit means the
    // difference left the DATA_W range; the extra bit gives the direction.
    assign w_ovf = w_diff[DATA_W] ^ w_diff[DATA_W-1];

    always_comb begin
        o_result = w_diff[DATA_W-1:0];
        if (w_ovf) begin
            o_result = w_diff[DATA_W] ? w_min : w_max;
        end
    end

    assign o_sat = w_ovf;
`else
    assign o_result = DATA_W'(w_diff >>> 1);
`endif

endmodule

// File: rtl/karaoke_vocal_remover.sv
// Pairs L/R ADC samples, optionally replaces both with the channel difference,
// and emits the pair to the DAC streams. KARAOKE_FULL_GAIN_EN enables sat_count.
module karaoke_vocal_remover
    import karaoke_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              vocal_remove,
    input  logic [DATA_W-1:0] adc_l_data,
    input  logic              adc_l_valid,
    output logic              adc_l_ready,
    input  logic [DATA_W-1:0] adc_r_data,
    input  logic              adc_r_valid,
    output logic              adc_r_ready,
    output logic [DATA_W-1:0] dac_l_data,
    output logic              dac_l_valid,
    input  logic              dac_l_ready,
    output logic [DATA_W-1:0] dac_r_data,
    output logic              dac_r_valid,
    input  logic              dac_r_ready,
    output logic [15:0]       sat_count
);

    state_t            r_state;
    logic [DATA_W-1:0] r_l;
    logic [DATA_W-1:0] r_r;
    logic              r_l_held;
    logic              r_r_held;
    logic              r_adc_l_ready;
    logic              r_adc_r_ready;
    logic [DATA_W-1:0] r_dac_l_data;
    logic [DATA_W-1:0] r_dac_r_data;
    logic              r_dac_l_valid;
    logic              r_dac_r_valid;

    logic              w_l_take;
    logic              w_r_take;
    logic              w_l_have;
    logic              w_r_have;
    logic              w_l_sent;
    logic              w_r_sent;
    logic [DATA_W-1:0] w_result;

    assign w_l_take = adc_l_valid & r_adc_l_ready;
    assign w_r_take = adc_r_valid & r_adc_r_ready;
    assign w_l_have = r_l_held | w_l_take;
    assign w_r_have = r_r_held | w_r_take;
    // A channel counts as sent once its valid is gone or is handshaking now.
    assign w_l_sent = ~r_dac_l_valid | dac_l_ready;
    assign w_r_sent = ~r_dac_r_valid | dac_r_ready;

`ifdef KARAOKE_FULL_GAIN_EN
    logic w_sat;

    karaoke_diff_sat #(
        .DATA_W (DATA_W)
    ) u_diff (
        .i_a      (r_l),
        .i_b      (r_r),
        .o_result (w_result),
        .o_sat    (w_sat)
    );
`else
    karaoke_diff_sat #(
        .DATA_W (DATA_W)
    ) u_diff (
        .i_a      (r_l),
        .i_b      (r_r),
        .o_result (w_result)
    );
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= CAPTURE;
            r_l           <= '0;
            r_r           <= '0;
            r_l_held      <= 1'b0;
            r_r_held      <= 1'b0;
            r_adc_l_ready <= 1'b0;
            r_adc_r_ready <= 1'b0;
            r_dac_l_data  <= '0;
            r_dac_r_data  <= '0;
            r_dac_l_valid <= 1'b0;
            r_dac_r_valid <= 1'b0;
        end else begin
            case (r_state)
                CAPTURE: begin
                    if (w_l_take) begin
                        r_l      <= adc_l_data;
                        r_l_held <= 1'b1;
                    end
                    if (w_r_take) begin
                        r_r      <= adc_r_data;
                        r_r_held <= 1'b1;
                    end
                    r_adc_l_ready <= ~w_l_have;
                    r_adc_r_ready <= ~w_r_have;
                    if (w_l_have && w_r_have) begin
                        r_state <= COMPUTE;
                    end
                end
                COMPUTE: begin
                    // The mode is latched here so both channels of a pair agree.
                    r_dac_l_data  <= vocal_remove ? w_result : r_l;
                    r_dac_r_data  <= vocal_remove ? w_result : r_r;
                    r_dac_l_valid <= 1'b1;
                    r_dac_r_valid <= 1'b1;
                    r_l_held      <= 1'b0;
                    r_r_held      <= 1'b0;
                    r_state       <= EMIT;
                end
                EMIT: begin
                    if (r_dac_l_valid && dac_l_ready) begin
                        r_dac_l_valid <= 1'b0;
                    end
                    if (r_dac_r_valid && dac_r_ready) begin
                        r_dac_r_valid <= 1'b0;
                    end
                    if (w_l_sent && w_r_sent) begin
                        r_adc_l_ready <= 1'b1;
                        r_adc_r_ready <= 1'b1;
                        r_state       <= CAPTURE;
                    end
                end
                default: begin
                    r_state <= CAPTURE;
                end
            endcase
        end
    end

`ifdef KARAOKE_FULL_GAIN_EN
    logic [15:0] r_sat_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sat_count <= '0;
        end else if (r_state == COMPUTE && vocal_remove && w_sat
                     && r_sat_count != 16'hFFFF) begin
            r_sat_count <= r_sat_count + 16'd1;
        end
    end

    assign sat_count = r_sat_count;
`else
    assign sat_count = '0;
`endif

    assign adc_l_ready = r_adc_l_ready;
    assign adc_r_ready = r_adc_r_ready;
    assign dac_l_data  = r_dac_l_data;
    assign dac_r_data  = r_dac_r_data;
    assign dac_l_valid = r_dac_l_valid;
    assign dac_r_valid = r_dac_r_valid;

endmodule
